datmem_arbiter: RTL and testbench

//  Shares the single-port data memory (Datmem) between two requesters: port A (CPU load/store) and port B (debug/DMA).

---
 rtl/datmem_arb_pkg.sv | 10 +
 rtl/datmem_arb_pick.sv | 31 +++
 rtl/datmem_arbiter.sv | 151 +++++++++++++++
 tb/tb_datmem_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/datmem_arb_pkg.sv
// Shared types and default sizes for the Datmem arbiter.
package datmem_arb_pkg;

    localparam int DEF_AWIDTH  = 32;
    localparam int DEF_ALENGTH = 128;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;
    typedef enum logic {PORT_A, PORT_B} port_id_t;

endpackage

// File: rtl/datmem_arb_pick.sv
// Combinational tie-break between the two requesters.
// DATMEM_ARB_RR_EN defined: round-robin against the last granted port.
// DATMEM_ARB_RR_EN undefined: fixed priority, port A wins every tie.
import datmem_arb_pkg::*;

module datmem_arb_pick (
    input  logic     req_a,
    input  logic     req_b,
`ifdef DATMEM_ARB_RR_EN
    input  port_id_t last_gnt,
`endif
    output port_id_t winner
);

    // Winner selection; the result only matters when at least one request is up.
    always_comb begin
        winner = PORT_A;
`ifdef DATMEM_ARB_RR_EN
        if (req_a && req_b) begin
            winner = (last_gnt == PORT_A) ? PORT_B : PORT_A;
        end else if (!req_a && req_b) begin
            winner = PORT_B;
        end
`else
        if (!req_a && req_b) begin
            winner = PORT_B;
        end
`endif
    end

endmodule

// File: rtl/datmem_arbiter.sv
// Two-port arbiter in front of the single-port Datmem.
// Each grant walks IDLE -> ACCESS -> DONE; Datmem is driven only in ACCESS.
// Writes to word 0 and to out-of-range words are dropped and flagged on Err.
// Optional macro DATMEM_ARB_RR_EN selects round-robin tie-break (default: A priority).
import datmem_arb_pkg::*;

module datmem_arbiter #(
    parameter int AWIDTH  = DEF_AWIDTH,
    parameter int ALENGTH = DEF_ALENGTH
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              ReqA,
    input  logic              WeA,
    input  logic [AWIDTH-1:0] AddrA,
    input  logic [AWIDTH-1:0] WDatA,
    output logic              AckA,
    output logic              ErrA,
    input  logic              ReqB,
    input  logic              WeB,
    input  logic [AWIDTH-1:0] AddrB,
    input  logic [AWIDTH-1:0] WDatB,
    output logic              AckB,
    output logic              ErrB,
    output logic [AWIDTH-1:0] RDat,
    output logic              WE2,
    output logic [AWIDTH-1:0] Addr,
    output logic [AWIDTH-1:0] WriDat,
    input  logic [AWIDTH-1:0] ReaDat
);

    arb_state_t        state_reg, state_next;
    port_id_t          gnt_reg, gnt_next;
    port_id_t          winner;
    logic              ack_a_reg, ack_a_next, err_a_reg, err_a_next;
    logic              ack_b_reg, ack_b_next, err_b_reg, err_b_next;
    logic [AWIDTH-1:0] rdat_reg, rdat_next;

    logic              sel_we;
    logic [AWIDTH-1:0] sel_addr, sel_wdat;
    logic              in_range, is_zero, wr_ok, err_now;

`ifdef DATMEM_ARB_RR_EN
    port_id_t          last_gnt_reg, last_gnt_next;

    datmem_arb_pick u_pick (
        .req_a    (ReqA),
        .req_b    (ReqB),
        .last_gnt (last_gnt_reg),
        .winner   (winner)
    );
`else
    datmem_arb_pick u_pick (
        .req_a    (ReqA),
        .req_b    (ReqB),
        .winner   (winner)
    );
`endif

    // Route the granted port's request fields and classify its address.
    assign sel_we   = (gnt_reg == PORT_A) ? WeA   : WeB;
    assign sel_addr = (gnt_reg == PORT_A) ? AddrA : AddrB;
    assign sel_wdat = (gnt_reg == PORT_A) ? WDatA : WDatB;
    assign in_range = (sel_addr < AWIDTH'(ALENGTH));
    assign is_zero  = (sel_addr == '0);
    assign wr_ok    = sel_we && !is_zero && in_range;
    assign err_now  = sel_we ? (is_zero || !in_range) : !in_range;

    // Next-state, completion flags and Datmem drive; Datmem sees the access only in ACCESS.
    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        ack_a_next = 1'b0;
        ack_b_next = 1'b0;
        err_a_next = 1'b0;
        err_b_next = 1'b0;
        rdat_next  = rdat_reg;
        WE2        = 1'b0;
        Addr       = '0;
        WriDat     = '0;
`ifdef DATMEM_ARB_RR_EN
        last_gnt_next = last_gnt_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (ReqA || ReqB) begin
                    gnt_next   = winner;
                    state_next = ACCESS;
`ifdef DATMEM_ARB_RR_EN
                    last_gnt_next = winner;
`endif
                end
            end
            ACCESS: begin
                Addr       = sel_addr;
                WriDat     = sel_wdat;
                // Rst_n gating keeps a reset that lands mid-access from writing.
                WE2        = wr_ok && Rst_n;
                rdat_next  = (in_range && !is_zero) ? ReaDat : '0;
                if (gnt_reg == PORT_A) begin
                    ack_a_next = 1'b1;
                    err_a_next = err_now;
                end else begin
                    ack_b_next = 1'b1;
                    err_b_next = err_now;
                end
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_reg <= IDLE;
            gnt_reg   <= PORT_B;
            ack_a_reg <= 1'b0;
            ack_b_reg <= 1'b0;
            err_a_reg <= 1'b0;
            err_b_reg <= 1'b0;
            rdat_reg  <= '0;
`ifdef DATMEM_ARB_RR_EN
            last_gnt_reg <= PORT_B;
`endif
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            ack_a_reg <= ack_a_next;
            ack_b_reg <= ack_b_next;
            err_a_reg <= err_a_next;
            err_b_reg <= err_b_next;
            rdat_reg  <= rdat_next;
`ifdef DATMEM_ARB_RR_EN
            last_gnt_reg <= last_gnt_next;
`endif
        end
    end

    assign AckA = ack_a_reg;
    assign AckB = ack_b_reg;
    assign ErrA = err_a_reg;
    assign ErrB = err_b_reg;
    assign RDat = rdat_reg;

endmodule

// File: tb/tb_datmem_arbiter.sv
// Self-checking bench for datmem_arbiter with a behavioural Datmem and reference model.
module tb_datmem_arbiter;
    import datmem_arb_pkg::*;

    localparam int AW = 32;
    localparam int AL = 128;

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b0;
    logic          ReqA = 1'b0, WeA = 1'b0, ReqB = 1'b0, WeB = 1'b0;
    logic [AW-1:0] AddrA = '0, WDatA = '0, AddrB = '0, WDatB = '0;
    logic          AckA, ErrA, AckB, ErrB, WE2;
    logic [AW-1:0] RDat, Addr, WriDat, ReaDat;

    int checks = 0;
    int errors = 0;

    datmem_arbiter #(.AWIDTH(AW), .ALENGTH(AL)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .ReqA(ReqA), .WeA(WeA), .AddrA(AddrA), .WDatA(WDatA), .AckA(AckA), .ErrA(ErrA),
        .ReqB(ReqB), .WeB(WeB), .AddrB(AddrB), .WDatB(WDatB), .AckB(AckB), .ErrB(ErrB),
        .RDat(RDat), .WE2(WE2), .Addr(Addr), .WriDat(WriDat), .ReaDat(ReaDat)
    );

    always #5 Clk = ~Clk;

    // Behavioural Datmem: word 0 hardwired zero, out-of-range reads return junk.
    logic [AW-1:0] mem [0:AL-1] = '{default: '0};
    assign ReaDat = (Addr < AL) ? mem[Addr[6:0]] : 32'hBAD0_0BAD;
    always @(posedge Clk) begin
        if (WE2 && Addr < AL && Addr != 0) mem[Addr[6:0]] <= WriDat;
    end

    int we2_count = 0;
    always @(posedge Clk) begin
        if (WE2) we2_count <= we2_count + 1;
    end

    // Reference memory contents, updated once per completed access.
    logic [AW-1:0] ref_mem [0:AL-1] = '{default: '0};

    function automatic logic [AW-1:0] model_read(input logic [AW-1:0] a);
        return (a != 0 && a < AL) ? ref_mem[a[6:0]] : '0;
    endfunction

    function automatic bit model_err(input bit we, input logic [AW-1:0] a);
        return we ? (a == 0 || a >= AL) : (a >= AL);
    endfunction

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One arbitrated access on a single port, compared against supplied expectations.
    task automatic do_access(input bit port, input bit we, input logic [AW-1:0] a,
                             input logic [AW-1:0] wd, input logic [AW-1:0] exp_rd,
                             input bit exp_err, input int exp_wr, input string tag);
        int cyc = 0;
        bit got = 0;
        int start = we2_count;
        logic we2_at1 = 1'b0;
        logic own_ack, other_ack, own_err;
        if (port == 0) begin ReqA = 1; WeA = we; AddrA = a; WDatA = wd; end
        else           begin ReqB = 1; WeB = we; AddrB = a; WDatB = wd; end
        while (!got && cyc < 10) begin
            @(posedge Clk); #1;
            cyc++;
            if (cyc == 1) we2_at1 = WE2;
            if (AckA || AckB) got = 1;
        end
        own_ack   = port ? AckB : AckA;
        other_ack = port ? AckA : AckB;
        own_err   = port ? ErrB : ErrA;
        check({tag, " latency"}, cyc, 2);
        check({tag, " ack"}, {31'b0, own_ack}, 1);
        check({tag, " other_ack"}, {31'b0, other_ack}, 0);
        check({tag, " err"}, {31'b0, own_err}, {31'b0, exp_err});
        if (!we) check({tag, " rdat"}, RDat, exp_rd);
        check({tag, " we2_cycle1"}, {31'b0, we2_at1}, (exp_wr != 0) ? 1 : 0);
        check({tag, " we2_count"}, we2_count - start, exp_wr);
        $display("txn %-10s port=%s we=%0d addr=%0d wdat=%h rdat=%h err=%0d",
                 tag, port ? "B" : "A", we, a, wd, RDat, own_err);
        if (we && !model_err(we, a)) ref_mem[a[6:0]] = wd;
        ReqA = 0; ReqB = 0;
        @(posedge Clk); #1;
    endtask

    typedef struct {
        bit            port;
        bit            we;
        logic [AW-1:0] addr;
        logic [AW-1:0] wdat;
        logic [AW-1:0] exp_rdat;
        bit            exp_err;
        int            exp_wr;
    } vec_t;

    task automatic pulse_reset();
        ReqA = 0; ReqB = 0;
        Rst_n = 0;
        repeat (2) @(posedge Clk);
        #1 Rst_n = 1;
        @(posedge Clk); #1;
    endtask

    initial begin
        vec_t vecs [10];
        port_id_t grants [4];
        logic [AW-1:0] gnt_rd [4];
        port_id_t exp_g [4];
        int n;
        int cyc;
        int start;
        int bad;

        // Reset holds off a pending write.
        ReqA = 1; WeA = 1; AddrA = 5; WDatA = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            @(posedge Clk); #1;
            check("rst we2", {31'b0, WE2}, 0);
            check("rst acka", {31'b0, AckA}, 0);
            check("rst rdat", RDat, 0);
            check("rst addr", Addr, 0);
            check("rst state", {30'b0, dut.state_reg}, {30'b0, IDLE});
            $display("txn reset cycle %0d we2=%0d acka=%0d", i, WE2, AckA);
        end
        ReqA = 0;
        #1 Rst_n = 1;
        @(posedge Clk); #1;
        check("rst no write", we2_count, 0);
        check("rst mem5", mem[5], 0);

        // Directed vectors with hand-derived expectations.
        vecs[0] = '{0, 1, 5,   32'hDEADBEEF, 0,            0, 1};
        vecs[1] = '{0, 0, 5,   0,            32'hDEADBEEF, 0, 0};
        vecs[2] = '{1, 1, 0,   32'h1234,     0,            1, 0};
        vecs[3] = '{1, 0, 0,   0,            0,            0, 0};
        vecs[4] = '{0, 0, 200, 0,            0,            1, 0};
        vecs[5] = '{0, 1, 200, 32'h55,       0,            1, 0};
        vecs[6] = '{1, 1, 127, 32'hCAFEF00D, 0,            0, 1};
        vecs[7] = '{1, 0, 127, 0,            32'hCAFEF00D, 0, 0};
        vecs[8] = '{0, 0, 128, 0,            0,            1, 0};
        vecs[9] = '{0, 1, 7,   32'h77777777, 0,            0, 1};
        for (int i = 0; i < 10; i++) begin
            do_access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdat,
                      vecs[i].exp_rdat, vecs[i].exp_err, vecs[i].exp_wr, $sformatf("vec%0d", i));
        end

        // Random single-port traffic against the reference model.
        for (int i = 0; i < 60; i++) begin
            bit p, w;
            logic [AW-1:0] a, d;
            int r;
            p = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            if (r == 0)      a = 0;
            else if (r == 1) a = $urandom_range(128, 300);
            else if (r == 2) a = 127;
            else             a = $urandom_range(1, 20);
            d = $urandom;
            do_access(p, w, a, d, model_read(a), model_err(w, a),
                      (w && !model_err(w, a)) ? 1 : 0, $sformatf("rnd%0d", i));
        end

        // Both ports held requesting for four grants.
        pulse_reset();
`ifdef DATMEM_ARB_RR_EN
        exp_g = '{PORT_A, PORT_B, PORT_A, PORT_B};
`else
        exp_g = '{PORT_A, PORT_A, PORT_A, PORT_A};
`endif
        ReqA = 1; WeA = 0; AddrA = 5;
        ReqB = 1; WeB = 0; AddrB = 127;
        n = 0; cyc = 0;
        while (n < 4 && cyc < 20) begin
            @(posedge Clk); #1;
            cyc++;
            if (AckA || AckB) begin
                grants[n] = AckA ? PORT_A : PORT_B;
                gnt_rd[n] = RDat;
                n++;
            end
        end
        ReqA = 0; ReqB = 0;
        check("tie count", n, 4);
        for (int i = 0; i < n; i++) begin
            check($sformatf("tie grant%0d", i), {31'b0, grants[i]}, {31'b0, exp_g[i]});
            check($sformatf("tie rdat%0d", i), gnt_rd[i],
                  model_read((grants[i] == PORT_A) ? 32'd5 : 32'd127));
            $display("txn tie%0d grant=%s rdat=%h", i, grants[i] == PORT_A ? "A" : "B", gnt_rd[i]);
        end
        @(posedge Clk); #1;

        // Reset lands during ACCESS of a B write to word 7.
        start = we2_count;
        ReqB = 1; WeB = 1; AddrB = 7; WDatB = 32'h12345678;
        @(posedge Clk); #1;
        check("abort in_access we2", {31'b0, WE2}, 1);
        Rst_n = 0; #1;
        check("abort gated we2", {31'b0, WE2}, 0);
        @(posedge Clk); #1;
        check("abort ackb", {31'b0, AckB}, 0);
        ReqB = 0;
        @(posedge Clk); #1;
        Rst_n = 1;
        check("abort ackb2", {31'b0, AckB}, 0);
        @(posedge Clk); #1;
        check("abort ackb3", {31'b0, AckB}, 0);
        check("abort no write", we2_count - start, 0);
        $display("txn abort B write word 7");
        do_access(0, 0, 7, 0, model_read(7), 0, 0, "abort_rd");

        // Final memory image must match the reference.
        bad = 0;
        for (int i = 0; i < AL; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("mem image", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
